cla_pipe_add_sub: RTL and testbench
===================================

// Module: cla_pipe_add_sub
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
//  Operand is split into BLOCK_SIZE-bit CLA groups; one group resolved per pipeline stage,
//  group carry registered into the next stage. valid/ready handshakes on both sides.
//  Produces sum, carry-out, signed overflow and zero flags.
// PARAMETERS
//  DATA_SIZE   16  operand/result width; must be a multiple of BLOCK_SIZE
//  BLOCK_SIZE  4   bits per CLA group = bits resolved per stage
//  (derived) NUM_BLOCKS = DATA_SIZE/BLOCK_SIZE = pipeline depth, >= 1
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst_n      in   1          synchronous, active-low reset
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          block accepts beat this cycle
//  a          in   DATA_SIZE  operand A
//  b          in   DATA_SIZE  operand B
//  cin        in   1          carry-in (add) / borrow-in (sub)
//  sub        in   1          0: A+B+cin   1: A-B-cin
//  sat        in   1          signed saturate (only with CLA_PIPE_SAT_EN)
//  out_valid  out  1          result beat valid
//  out_ready  in   1          downstream accepts result
//  sum        out  DATA_SIZE  result
//  c_out      out  1          raw carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1          signed overflow = carry into MSB ^ carry out of MSB
//  zero       out  1          sum == 0 (after saturation if applied)
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): all stage valids, out_valid, sum, c_out, overflow,
//    zero = 0; in_ready follows stall rule (1 after reset). Reset mid-stream drops all
//    in-flight beats; no partial result ever emitted.
//  - Operand prep at entry: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
//  - Stage k (0..NUM_BLOCKS-1): g=a&b_eff, p=a^b_eff per bit; lookahead carries in group
//    from registered carry c_k; registers sum bits [k*BLOCK_SIZE +: BLOCK_SIZE] and
//    group carry out. Unresolved upper operand bits and finished lower sum bits travel
//    with the beat (skewed pipeline). Last stage also registers MSB carry-in for overflow.
//  - Latency: NUM_BLOCKS cycles from accept (in_valid&in_ready) to out_valid, no stall.
//    Throughput one beat/cycle.
//  - Stall: adv = !out_valid | out_ready; in_ready = adv. When adv=0 every stage holds
//    (valid+data); no bubble compaction. out_* stable while out_valid & !out_ready.
//  - Beat accepted only when in_valid & in_ready; bubbles (in_valid=0) propagate as
//    valid=0 stages. Order strictly preserved; no loss, no duplication.
//  - sum/flags undefined-but-stable when out_valid=0 (hold last value).
//  - Width: c_out is carry of bit DATA_SIZE-1; NUM_BLOCKS=1 gives latency 1.
//  - Elaboration error if DATA_SIZE % BLOCK_SIZE != 0.
// CONFIGURATION
//  CLA_PIPE_SAT_EN defined: port sat exists, captured with the beat; if sat=1 and
//    overflow=1, sum = MSB-of-A ? {1,0..0} : {0,1..1} (signed min/max); overflow
//    still reported as 1; zero computed on saturated sum; c_out unchanged (raw).
//  Not defined: no sat port, sum always wraps modulo 2^DATA_SIZE.
// TESTING (DATA_SIZE=16, BLOCK_SIZE=4, latency 4)
//  1 add 0x7FFF+0x0001 cin=0 -> 4 cyc later sum=0x8000 c_out=0 overflow=1 zero=0
//  2 add 0xFFFF+0x0001 cin=0 -> sum=0x0000 c_out=1 overflow=0 zero=1; cin=1 on 0x00FF+0 -> 0x0100
//  3 sub 0x0005-0x0007 cin=0 -> sum=0xFFFE c_out=0 overflow=0; sub 0x8000-0x0001 -> 0x7FFF ovf=1
//  4 8 back-to-back beats, out_ready=0 for 3 cycles mid-stream -> in_ready=0 same 3 cycles,
//    outputs held, all 8 results in order, none lost/duplicated
//  5 rst_n low 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale result later
//  6 CLA_PIPE_SAT_EN, sat=1: 0x7FFF+1 -> 0x7FFF ovf=1; sub 0x8000-1 -> 0x8000 ovf=1; sat=0 wraps

Source files
------------

// File: rtl/cla_pipe_add_sub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK_SIZE-bit CLA group resolved per stage.
// Defining CLA_PIPE_SAT_EN adds the sat port and signed saturation of the result.
module cla_pipe_add_sub #(
  parameter int DATA_SIZE  = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
`ifdef CLA_PIPE_SAT_EN
  input  logic                 sat,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] sum,
  output logic                 c_out,
  output logic                 overflow,
  output logic                 zero
);
  localparam int NUM_BLOCKS = DATA_SIZE / BLOCK_SIZE;

  if (BLOCK_SIZE < 1 || DATA_SIZE < BLOCK_SIZE || (DATA_SIZE % BLOCK_SIZE) != 0) begin : g_bad_cfg
    $error("cla_pipe_add_sub: DATA_SIZE must be a non-zero multiple of BLOCK_SIZE");
  end

  // Stage k output registers; the last stage writes the dedicated result registers instead.
  logic                 v_reg [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] a_reg [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] b_reg [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] s_reg [NUM_BLOCKS];
  logic                 c_reg [NUM_BLOCKS];

  // Inputs seen by stage k and its combinational results.
  logic                 st_v  [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] st_a  [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] st_b  [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] st_s  [NUM_BLOCKS];
  logic                 st_c  [NUM_BLOCKS];
  logic [DATA_SIZE-1:0] nxt_s [NUM_BLOCKS];
  logic                 nxt_c [NUM_BLOCKS];

`ifdef CLA_PIPE_SAT_EN
  logic                 sat_reg [NUM_BLOCKS];
  logic                 st_sat  [NUM_BLOCKS];
  assign st_sat[0] = sat;
`endif

  logic                 msb_cin;
  logic [DATA_SIZE-1:0] fin_s;
  logic                 fin_ovf;
  logic [DATA_SIZE-1:0] sum_reg;
  logic                 c_out_reg;
  logic                 ovf_reg;
  logic                 zero_reg;
  logic                 adv;

  // The whole pipe freezes together whenever a presented result is not taken.
  assign adv      = !v_reg[NUM_BLOCKS-1] || out_ready;
  assign in_ready = adv;

  assign st_v[0] = in_valid;
  assign st_a[0] = a;
  assign st_b[0] = sub ? ~b : b;
  assign st_c[0] = sub ? ~cin : cin;
  assign st_s[0] = '0;

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_stage
    localparam int LO = gi * BLOCK_SIZE;
    logic [BLOCK_SIZE-1:0] g;
    logic [BLOCK_SIZE-1:0] p;
    logic [BLOCK_SIZE:0]   c;
    logic                  gen_acc;
    logic                  prop_acc;
    logic [DATA_SIZE-1:0]  s_new;

    if (gi > 0) begin : g_link
      assign st_v[gi] = v_reg[gi-1];
      assign st_a[gi] = a_reg[gi-1];
      assign st_b[gi] = b_reg[gi-1];
      assign st_s[gi] = s_reg[gi-1];
      assign st_c[gi] = c_reg[gi-1];
`ifdef CLA_PIPE_SAT_EN
      assign st_sat[gi] = sat_reg[gi-1];
`endif
    end

    // Each carry is the flat sum-of-products over generate/propagate terms of its group.
    always_comb begin
      g        = st_a[gi][LO +: BLOCK_SIZE] & st_b[gi][LO +: BLOCK_SIZE];
      p        = st_a[gi][LO +: BLOCK_SIZE] ^ st_b[gi][LO +: BLOCK_SIZE];
      c        = '0;
      c[0]     = st_c[gi];
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        gen_acc  = 1'b0;
        prop_acc = 1'b1;
        for (int j = i; j >= 0; j--) begin
          gen_acc  = gen_acc | (prop_acc & g[j]);
          prop_acc = prop_acc & p[j];
        end
        c[i+1] = gen_acc | (prop_acc & st_c[gi]);
      end
      s_new                   = st_s[gi];
      s_new[LO +: BLOCK_SIZE] = p ^ c[BLOCK_SIZE-1:0];
    end

    assign nxt_s[gi] = s_new;
    assign nxt_c[gi] = c[BLOCK_SIZE];

    if (gi == NUM_BLOCKS - 1) begin : g_last
      assign msb_cin = c[BLOCK_SIZE-1];
    end
  end

  always_comb begin
    fin_ovf = nxt_c[NUM_BLOCKS-1] ^ msb_cin;
    fin_s   = nxt_s[NUM_BLOCKS-1];
`ifdef CLA_PIPE_SAT_EN
    // On overflow the true result has the sign of A, so clamp toward that sign.
    if (st_sat[NUM_BLOCKS-1] && fin_ovf) begin
      fin_s = {st_a[NUM_BLOCKS-1][DATA_SIZE-1], {(DATA_SIZE-1){~st_a[NUM_BLOCKS-1][DATA_SIZE-1]}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        v_reg[k] <= 1'b0;
      end
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        v_reg[k] <= st_v[k];
      end
      for (int k = 0; k < NUM_BLOCKS - 1; k++) begin
        a_reg[k] <= st_a[k];
        b_reg[k] <= st_b[k];
        s_reg[k] <= nxt_s[k];
        c_reg[k] <= nxt_c[k];
`ifdef CLA_PIPE_SAT_EN
        sat_reg[k] <= st_sat[k];
`endif
      end
      // Result registers keep the last real beat across bubbles.
      if (st_v[NUM_BLOCKS-1]) begin
        sum_reg   <= fin_s;
        c_out_reg <= nxt_c[NUM_BLOCKS-1];
        ovf_reg   <= fin_ovf;
        zero_reg  <= ~|fin_s;
      end
    end
  end

  assign out_valid = v_reg[NUM_BLOCKS-1];
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign overflow  = ovf_reg;
  assign zero      = zero_reg;
endmodule

// File: tb/tb_cla_pipe_add_sub.sv
// Scoreboard bench for cla_pipe_add_sub: directed corner cases, stall, reset flush, random traffic.
// Saturation cases are exercised when CLA_PIPE_SAT_EN is defined.
module tb_cla_pipe_add_sub;
  localparam int DW = 16;
  localparam int BW = 4;
  localparam int NB = DW / BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] sum;
  logic          c_out;
  logic          overflow;
  logic          zero;

  always #5 clk = ~clk;

  cla_pipe_add_sub #(.DATA_SIZE(DW), .BLOCK_SIZE(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef CLA_PIPE_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct {
    logic [DW-1:0] sum;
    logic          c_out;
    logic          ovf;
    logic          zero;
    int            acc_cyc;
    int            acc_stall;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   beats_out = 0;
  logic rand_rdy = 1'b0;
  logic force_rdy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                                 input logic tc, input logic ts, input logic tsat);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr, lim, maxs, mins;
    ua   = longint'(ta);
    ub   = longint'(tb_);
    sa   = longint'($signed(ta));
    sb   = longint'($signed(tb_));
    lim  = longint'(1) << DW;
    maxs = (longint'(1) << (DW - 1)) - 1;
    mins = -(longint'(1) << (DW - 1));
    if (!ts) begin
      r       = ua + ub + longint'(tc);
      sr      = sa + sb + longint'(tc);
      e.c_out = (r >= lim);
    end else begin
      r       = ua - ub - longint'(tc);
      sr      = sa - sb - longint'(tc);
      e.c_out = (ua >= ub + longint'(tc));
    end
    e.sum = r[DW-1:0];
    e.ovf = (sr > maxs) || (sr < mins);
    if (tsat && e.ovf) e.sum = (sr > 0) ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
    e.zero      = (e.sum == '0);
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drives one beat, waits (bounded) for acceptance, pushes the expected result.
  task automatic send_exp(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic tc,
                          input logic ts, input logic tsat, input logic use_model,
                          input logic [DW-1:0] xs, input logic xc, input logic xo);
    exp_t e;
    int   n;
    logic ok;
    a = ta; b = tb_; cin = tc; sub = ts; sat = tsat; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n <= 200) begin
      @(negedge clk);
      if (in_ready && rst_n) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no in_ready in %0d cycles, expected acceptance", n);
    end else begin
      if (use_model) e = model(ta, tb_, tc, ts, tsat);
      else begin
        e.sum = xs; e.c_out = xc; e.ovf = xo; e.zero = (xs == '0);
      end
      e.acc_cyc   = cyc;
      e.acc_stall = stall_cnt;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic tsat);
    logic [DW-1:0] ra, rb;
    logic [DW-1:0] pick [5];
    pick[0] = '0; pick[1] = '1; pick[2] = {1'b0, {(DW-1){1'b1}}};
    pick[3] = {1'b1, {(DW-1){1'b0}}}; pick[4] = DW'($urandom);
    ra = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : DW'($urandom);
    rb = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : DW'($urandom);
    send_exp(ra, rb, 1'($urandom), 1'($urandom), tsat, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check1("drain_queue_empty", q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  // Monitor: handshake rule, output hold during stall, in-order result and latency.
  logic [DW-1:0] h_sum;
  logic          h_c, h_o, h_z, held = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      check1("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (held) begin
        check1("stall_hold", {out_valid, c_out, overflow, zero, sum}, {1'b1, h_c, h_o, h_z, h_sum});
      end
      held = out_valid && !out_ready;
      if (held) begin
        h_sum = sum; h_c = c_out; h_o = overflow; h_z = zero;
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got sum=%h with out_valid=1, expected no beat", sum);
        end else begin
          e = q.pop_front();
          beats_out++;
          $display("beat %0d: sum=%h c_out=%b ovf=%b zero=%b (exp sum=%h c_out=%b ovf=%b zero=%b)",
                   beats_out, sum, c_out, overflow, zero, e.sum, e.c_out, e.ovf, e.zero);
          check1("result", {sum, c_out, overflow, zero}, {e.sum, e.c_out, e.ovf, e.zero});
          check1("latency", cyc - e.acc_cyc, NB + stall_cnt - e.acc_stall);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("reset_out_valid", out_valid, 0);
    check1("reset_in_ready", in_ready, 1);
    check1("reset_sum", sum, 0);
    check1("reset_flags", {c_out, overflow, zero}, 0);
    @(posedge clk); #1;

    // Directed corner cases with hand-derived results.
    send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_exp(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_exp(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send_exp(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_exp(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
`ifdef CLA_PIPE_SAT_EN
    send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
    send_exp(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
    send_exp(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    drain();

    // Eight back-to-back beats with a three-cycle downstream stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        force_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check1("stall_in_ready_low", {in_ready, out_valid}, 2'b01);
          @(posedge clk);
        end
        force_rdy = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: nothing from them may ever appear.
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check1("post_reset_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send_exp(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
    drain();

    // Random traffic with bubbles and random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
`ifdef CLA_PIPE_SAT_EN
      send_rand(1'($urandom));
`else
      send_rand(1'b0);
`endif
    end
    drain();
    rand_rdy = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
